// File: rtl/iic_rd_engine.sv
// Command-driven I2C single-register read master for the LM80 monitor buses.
// Optional bus-clear preamble before START is enabled by defining IIC_BUS_CLEAR_EN.
module iic_rd_engine #(
    parameter int unsigned CLK_DIV  = 250,
    parameter logic [6:0]  DEV_ADDR = 7'h28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_ch,
    input  logic [7:0] cmd_reg,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic [7:0] iic_sel,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);

    typedef enum logic [3:0] {
        StIdle, StStart, StAddrW, StAck1, StReg, StAck2, StRstart, StAddrR, StAck3,
        StRead, StMnack, StStop,
`ifdef IIC_BUS_CLEAR_EN
        StClear, StClrStop,
`endif
        StDone
    } state_e;

    state_e      st_q, st_d, st_succ;
    logic [1:0]  q_q, q_d;
    logic [3:0]  bit_q, bit_d, bit_last;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  reg_q, rx_q, sel_q, rsp_data_q, tx_byte;
    logic        nack_q, rsp_valid_q, rsp_nack_q, scl_q, sda_oe_q;
    logic        busy, tick, accept, wave_scl, wave_sda;

    assign busy   = (st_q != StIdle) && (st_q != StDone);
    assign tick   = busy && (cnt_q == 16'd0);
    assign accept = (st_q == StIdle) && cmd_valid;

    // Accept is quarter tick 0, so the counter restarts at 1 on the following cycle.
    always_comb begin
        cnt_d = 16'd0;
        if (accept) begin
            cnt_d = 16'd1;
        end else if (busy) begin
            cnt_d = (cnt_q == 16'(CLK_DIV - 1)) ? 16'd0 : cnt_q + 16'd1;
        end
    end

    always_comb begin
        bit_last = 4'd0;
        st_succ  = StIdle;
        case (st_q)
            StAddrW, StReg, StAddrR, StRead: bit_last = 4'd7;
`ifdef IIC_BUS_CLEAR_EN
            StClear:                         bit_last = 4'd8;
`endif
            default:                         bit_last = 4'd0;
        endcase
        case (st_q)
            StStart:   st_succ = StAddrW;
            StAddrW:   st_succ = StAck1;
            StAck1:    st_succ = nack_q ? StStop : StReg;
            StReg:     st_succ = StAck2;
            StAck2:    st_succ = nack_q ? StStop : StRstart;
            StRstart:  st_succ = StAddrR;
            StAddrR:   st_succ = StAck3;
            StAck3:    st_succ = nack_q ? StStop : StRead;
            StRead:    st_succ = StMnack;
            StMnack:   st_succ = StStop;
            StStop:    st_succ = StDone;
`ifdef IIC_BUS_CLEAR_EN
            StClear:   st_succ = StClrStop;
            StClrStop: st_succ = StStart;
`endif
            default:   st_succ = StIdle;
        endcase
    end

    always_comb begin
        st_d  = st_q;
        q_d   = q_q;
        bit_d = bit_q;
        case (st_q)
            StIdle: begin
                if (cmd_valid) begin
`ifdef IIC_BUS_CLEAR_EN
                    st_d = StClear;
`else
                    st_d = StStart;
`endif
                    q_d   = 2'd0;
                    bit_d = 4'd0;
                end
            end
            StDone: st_d = StIdle;
            default: begin
                if (tick) begin
                    if (q_q != 2'd3) begin
                        q_d = q_q + 2'd1;
                    end else begin
                        q_d = 2'd0;
                        if (bit_q != bit_last) begin
                            bit_d = bit_q + 4'd1;
                        end else begin
                            bit_d = 4'd0;
                            st_d  = st_succ;
                        end
                    end
                end
            end
        endcase
    end

    // Waveform of the quarter about to start; wave_sda = 1 means released.
    always_comb begin
        case (st_d)
            StAddrW: tx_byte = {DEV_ADDR, 1'b0};
            StReg:   tx_byte = reg_q;
            StAddrR: tx_byte = {DEV_ADDR, 1'b1};
            default: tx_byte = 8'hFF;
        endcase
        wave_scl = 1'b1;
        wave_sda = 1'b1;
        case (st_d)
            StStart: begin
                wave_scl = 1'b1;
                wave_sda = ~q_d[1];
            end
            StAddrW, StReg, StAddrR, StMnack: begin
                wave_scl = q_d[1];
                wave_sda = tx_byte[3'd7 - bit_d[2:0]];
            end
            StAck1, StAck2, StAck3, StRead: begin
                wave_scl = q_d[1];
                wave_sda = 1'b1;
            end
            StRstart: begin
                wave_scl = (q_d != 2'd0);
                wave_sda = ~q_d[1];
            end
            StStop: begin
                wave_scl = (q_d != 2'd0);
                wave_sda = q_d[1];
            end
`ifdef IIC_BUS_CLEAR_EN
            StClear: begin
                wave_scl = q_d[1];
                wave_sda = 1'b1;
            end
            StClrStop: begin
                wave_scl = (q_d != 2'd0);
                wave_sda = q_d[1];
            end
`endif
            default: begin
                wave_scl = 1'b1;
                wave_sda = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= StIdle;
            q_q         <= 2'd0;
            bit_q       <= 4'd0;
            cnt_q       <= 16'd0;
            reg_q       <= 8'h00;
            rx_q        <= 8'h00;
            nack_q      <= 1'b0;
            sel_q       <= 8'hFF;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_nack_q  <= 1'b0;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            q_q      <= q_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            scl_q    <= wave_scl;
            sda_oe_q <= ~wave_sda;
            if (accept) begin
                reg_q  <= cmd_reg;
                sel_q  <= {5'b0, cmd_ch};
                nack_q <= 1'b0;
                rx_q   <= 8'h00;
            end else if (st_q == StDone) begin
                sel_q <= 8'hFF;
            end
            // Sample at the tick that ends quarter 2, while SCL is high.
            if (tick && (q_q == 2'd2)) begin
                if ((st_q == StAck1) || (st_q == StAck2) || (st_q == StAck3)) begin
                    nack_q <= sda_in;
                end else if (st_q == StRead) begin
                    rx_q <= {rx_q[6:0], sda_in};
                end
            end
            rsp_valid_q <= 1'b0;
            if ((st_d == StDone) && (st_q != StDone)) begin
                rsp_valid_q <= 1'b1;
                rsp_nack_q  <= nack_q;
                rsp_data_q  <= nack_q ? 8'h00 : rx_q;
            end
        end
    end

    assign cmd_ready = (st_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_nack  = rsp_nack_q;
    assign iic_sel   = sel_q;
    assign scl       = scl_q;
    assign sda_oe    = sda_oe_q;

endmodule

// File: doc/iic_rd_engine.md
Name: iic_rd_engine

Overview:
- Command-driven I2C read master for the LM80 monitor buses. Generates the shared `scl`, the SDA drive and the 8-bit `iic_sel` channel code.
- Feeds the downstream SCL/channel fan-out stage, which routes `scl` to bus `iic_sel` (0-7) and tri-states every bus for any other code.
- Each command performs one register read on one channel: START, addr+W, reg, repeated START, addr+R, data byte, master NACK, STOP.

Parameters:
- CLK_DIV, 250: `clk` cycles per SCL quarter-period. Legal range 2..65535.
- DEV_ADDR, 7'h28: 7-bit I2C slave address used for every transaction.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high
- cmd_ch  in  3  target channel
- cmd_reg  in  8  register address to read
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  8  read byte; held until the next rsp_valid
- rsp_nack  out  1  slave NACK seen; held like rsp_data
- iic_sel  out  8  {5'b0, channel} while busy; 8'hFF when idle
- scl  out  1  I2C clock
- sda_oe  out  1  1 = pull SDA low, 0 = release SDA
- sda_in  in  1  sampled SDA line

Behaviour:
- Reset values: scl=1, sda_oe=0, iic_sel=8'hFF, cmd_ready=1, rsp_valid=0, rsp_data=8'h00, rsp_nack=0. The quarter counter is cleared and the FSM goes to IDLE.
- On accept: latch cmd_ch and cmd_reg, drive iic_sel={5'b0,cmd_ch}, set cmd_ready=0.
- Quarter timing:
  - The counter runs only while busy.
  - The accept cycle is cycle 0.
  - Quarter tick k occurs at cycle k*CLK_DIV.
  - Output changes register on the tick cycle.
- Units are 4 quarters each. scl / SDA per quarter (SDA 0 means sda_oe=1):
  - START: scl 1,1,1,1; SDA 1,1,0,0.
  - Data bit b: scl 0,0,1,1; SDA = b for all 4 quarters. MSB first.
  - Slave ACK slot: scl 0,0,1,1; SDA released; sda_in is sampled on the tick that ends quarter 2.
  - Master read bit: same as a slave ACK slot; the sample is shifted into the data register.
  - Master NACK: data bit with b=1.
  - RSTART: scl 0,1,1,1; SDA 1,1,0,0.
  - STOP: scl 0,1,1,1; SDA 0,0,1,1.
- FSM: IDLE -> START -> ADDR_W (8 bits, byte {DEV_ADDR,0}) -> ACK1 -> REG (8 bits) -> ACK2 -> RSTART -> ADDR_R (8 bits, byte {DEV_ADDR,1}) -> ACK3 -> READ (8 bits) -> MNACK -> STOP -> DONE -> IDLE.
- Full transaction is 156 quarters. The final tick is at cycle 156*CLK_DIV; DONE at cycle 156*CLK_DIV+1 asserts rsp_valid for one cycle.
- Sampled sda_in=1 in ACK1, ACK2 or ACK3 is a NACK: go directly to STOP, then DONE with rsp_nack=1 and rsp_data=8'h00.
- Early-termination quarter counts:
  - NACK at ACK1: 44 quarters.
  - NACK at ACK2: 80 quarters.
  - NACK at ACK3: 120 quarters.
- The DONE cycle has cmd_ready=0 and iic_sel still the channel code. IDLE follows: iic_sel=8'hFF, cmd_ready=1, scl=1, sda_oe=0.
- cmd_valid while busy is ignored; there is no queueing.
- iic_sel never changes mid-transaction.
- rst mid-transaction: on the next cycle all outputs return to their reset values and no rsp_valid is produced. Bus recovery is covered by the optional feature.

Optional Feature:
- Macro IIC_BUS_CLEAR_EN.
- Defined: a CLEAR phase is inserted between accept and START. It issues 9 units of scl 0,0,1,1 with SDA released, plus one STOP unit (10 units, 40 quarters), with iic_sel already set to the channel.
  - Full transaction is 196 quarters.
  - NACK-at-ACK1 case is 84 quarters.
- Undefined: no CLEAR state; timing is as in Behaviour.

Test Plan (CLK_DIV=4, DEV_ADDR=7'h28):
- Reset asserted 3 cycles -> scl=1, sda_oe=0, iic_sel=8'hFF, cmd_ready=1, rsp_valid=0, rsp_data=8'h00, rsp_nack=0.
- Command ch=3, reg=8'h05; slave model ACKs all bytes and returns 8'hA5:
  - bytes 8'h50, 8'h05, 8'h51 appear on SDA;
  - iic_sel=8'h03 through cycle 625; rsp_valid at cycle 625 with rsp_data=8'hA5, rsp_nack=0;
  - iic_sel=8'hFF at cycle 626.
- Command ch=7; address NACKed -> STOP issued, rsp_valid at cycle 177, rsp_nack=1, rsp_data=8'h00.
- Command ch=1; register byte NACKed -> rsp_valid at cycle 321, rsp_nack=1.
- cmd_valid held high continuously with two commands queued:
  - the second command is ignored until cycle 626;
  - it is accepted in cycle 626 and its rsp_valid occurs at cycle 1251.
- rst pulsed at cycle 300 of a transaction -> cycle 301 shows reset values; a subsequent command completes normally with correct data.
